rr_arb4_lowgnt: RTL and testbench
=================================

Name: rr_arb4_lowgnt

Overview:
- Four-requester round-robin arbiter that shares one resource (bus or device select) among requesters 0..3.
- Grants are driven as active-low one-hot selects, compatible with our active-low 2-to-4 select fabric, plus a binary grant index.
- A hold-limit counter forces release of a requester that keeps the resource too long.
- Sits between requester blocks and the shared resource's select lines.

Parameters:
- MAX_HOLD, 16, maximum consecutive GRANT cycles per grant (legal range 2..256).
- CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  active-high request per requester; held high for as long as the resource is needed.
- gnt_n  output  4  active-low one-hot grant; 4'b1111 when no grant.
- gnt_idx  output  2  binary index of the current/last granted requester.
- gnt_valid  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (async assert, sync release via flops) values:
  - state = IDLE
  - gnt_n = 4'b1111
  - gnt_idx = 2'd3, so requester 0 has top priority first
  - gnt_valid = 0, timeout = 0, hold_cnt = 0
- All outputs are registered.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0 at a clock edge, choose the winner and go to GRANT.
  - Grant appears on the outputs the cycle after req is sampled (1-cycle latency).
  - hold_cnt is loaded with 0.
- Winner selection: the first set req bit searching from (gnt_idx+1) mod 4 upward, wrapping.
  - Example: gnt_idx=1, req=4'b1011 -> winner 3.
- GRANT:
  - gnt_n = ~(4'b0001 << gnt_idx), gnt_valid = 1, hold_cnt increments each cycle.
  - If req[gnt_idx] == 0: release and go to GAP (no timeout).
  - Else if hold_cnt == MAX_HOLD-1: release, go to GAP, and pulse timeout for 1 cycle, coincident with the first GAP cycle.
  - Else stay in GRANT.
  - A grant therefore lasts at most MAX_HOLD cycles.
- GAP:
  - Exactly one turnaround cycle with gnt_n = 4'b1111 and gnt_valid = 0; no two grants are ever adjacent.
  - Arbitrate as in IDLE: if req != 0, go to GRANT with the new winner on the next cycle; else go to IDLE.
  - gnt_idx retains the last winner through GAP and IDLE.
- Timed-out requester: it gets no special mask. Round-robin order puts it last. If it is the only requester, it is re-granted after the GAP cycle.
- Requests that rise and fall while another requester is granted are not latched; they are only seen if high at an arbitration edge.
- The onehot invariant holds every cycle: gnt_n is either 4'b1111 or exactly one bit low.
- Reset mid-grant: outputs return to reset values immediately (asynchronously). After rst_n deasserts, arbitration restarts from IDLE with requester 0 highest priority.
- req values of X/Z are out of scope; the bench drives known values only.

Decomposition:
- Shared package rr_arb_pkg contains:
  - state enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2)
  - constant NO_GNT_N = 4'b1111
  - constant RST_IDX = 2'd3
- One sub-module is natural: rr_pick4, combinational. Inputs are req[3:0] and last_idx[1:0]; outputs are win_idx[1:0] and any_req.
- The active-low one-hot encode (idx -> gnt_n) is inline in the registered output logic.

Test Plan:
- Reset then req=4'b0001 held 5 cycles, dropped: gnt_n=4'b1110 from cycle 1 to 5 after sampling; then 1 GAP cycle with 4'b1111; then IDLE. timeout never pulses.
- req=4'b1111 held constant, MAX_HOLD=4: grants rotate 0,1,2,3,0. Each lasts 4 cycles with a timeout pulse after each, and a 4'b1111 gap cycle between grants.
- gnt_idx=1 granted, req changes to 4'b1011 then req[1] drops: after GAP, gnt_n=4'b0111 (idx 3), not idx 0.
- Single requester 2 held for 20 cycles, MAX_HOLD=16: grant 16 cycles, timeout=1, gap of 1 cycle, then re-grant to 2 with gnt_n=4'b1011.
- rst_n pulled low mid-GRANT (idx 2): gnt_n goes to 4'b1111, gnt_valid=0, gnt_idx=3 asynchronously. After release with req=4'b0101, the first grant goes to idx 0.
- Randomized 2000 cycles, with assertions: gnt_n is always one-hot-low or all-ones; no consecutive grants without a gap; grant length <= MAX_HOLD; the granted bit's req was high at the arbitration edge.

Source files
------------

// File: rtl/rr_arb4_lowgnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared constants for the 4-way round-robin arbiter with
//               active-low one-hot grants. State encodings, the idle grant
//               pattern and the reset grant index.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    // Active-low select pattern when nobody owns the resource
    localparam logic [3:0] NO_GNT_N = 4'b1111;

    // Reset "last winner": the search starts at index 0 after reset
    localparam logic [1:0] RST_IDX = 2'd3;

endpackage : rr_arb_pkg
`default_nettype wire

// File: rtl/rr_arb4_lowgnt_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4_lowgnt_if
// Description : Request/grant bundle between the requesters and the arbiter.
//   req       - active-high request per requester (driven by master)
//   gnt_n     - active-low one-hot grant, 4'b1111 when idle
//   gnt_idx   - binary index of current/last winner
//   gnt_valid - high while a grant is asserted
//   timeout   - one-cycle pulse when the hold limit revokes a grant
//   modport master : requester side; modport slave : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arb4_lowgnt_if;
    logic [3:0] req;
    logic [3:0] gnt_n;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        input  gnt_n,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt_n,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface : rr_arb4_lowgnt_if
`default_nettype wire

// File: rtl/rr_arb4_lowgnt_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin winner search. Scans req starting
//               at (last_idx+1) mod 4 upward with wrap and returns the first
//               set bit.
//   req[3:0]      - request vector
//   last_idx[1:0] - previous winner (lowest priority this round)
//   win_idx[1:0]  - selected winner (equals last_idx when no request)
//   any_req       - at least one request bit set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last_idx,
    output logic [1:0] win_idx,
    output logic       any_req
);

    logic [1:0] w_cand;
    logic       w_found;

    always_comb begin
        win_idx = last_idx;
        w_cand  = '0;
        w_found = 1'b0;
        // Offsets 1..4; offset 4 wraps back to last_idx itself so a lone
        // requester that just finished can win again.
        for (int i = 1; i <= 4; i++) begin
            w_cand = last_idx + 2'(i);
            if (!w_found && req[w_cand]) begin
                win_idx = w_cand;
                w_found = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_arb4_lowgnt.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4_lowgnt
// Description : Four-requester round-robin arbiter with active-low one-hot
//               grants, a one-cycle turnaround gap between grants and a
//               hold-limit counter that revokes long grants.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - request/grant bundle (slave modport): req in; gnt_n, gnt_idx,
//           gnt_valid, timeout out (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb4_lowgnt
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,   // max consecutive grant cycles, 2..256
    parameter int CNT_W    = 8     // 2**CNT_W >= MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arb4_lowgnt_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_gnt_idx;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [3:0]       r_gnt_n;
    logic             r_gnt_valid;
    logic             r_timeout;

    logic [1:0]       w_win_idx;
    logic             w_any_req;

    rr_pick4 u_pick (
        .req      (bus.req),
        .last_idx (r_gnt_idx),
        .win_idx  (w_win_idx),
        .any_req  (w_any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt_idx   <= RST_IDX;
            r_hold_cnt  <= '0;
            r_gnt_n     <= NO_GNT_N;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                GRANT: begin
                    if (!bus.req[r_gnt_idx]) begin
                        r_state     <= GAP;
                        r_gnt_n     <= NO_GNT_N;
                        r_gnt_valid <= 1'b0;
                    end else if (r_hold_cnt == c_hold_last) begin
                        // Hold limit reached: revoke; pulse lines up with
                        // the first gap cycle.
                        r_state     <= GAP;
                        r_gnt_n     <= NO_GNT_N;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE and GAP arbitrate identically; gnt_idx keeps the
                    // last winner so the rotation continues across idle time.
                    if (w_any_req) begin
                        r_state     <= GRANT;
                        r_gnt_idx   <= w_win_idx;
                        r_hold_cnt  <= '0;
                        r_gnt_n     <= ~(4'b0001 << w_win_idx);
                        r_gnt_valid <= 1'b1;
                    end else begin
                        r_state     <= IDLE;
                        r_gnt_n     <= NO_GNT_N;
                        r_gnt_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.gnt_n     = r_gnt_n;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule : rr_arb4_lowgnt
`default_nettype wire

// File: tb/tb_rr_arb4_lowgnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb4_lowgnt
// Description : Self-checking bench for rr_arb4_lowgnt. Two instances: one
//               with MAX_HOLD=16 and one with MAX_HOLD=4. Directed scenarios
//               with hand-computed expectations, then a randomized run on
//               the MAX_HOLD=4 instance against a small reference model.
//               Status vectors are {gnt_n, gnt_idx, gnt_valid, timeout}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb4_lowgnt;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    rr_arb4_lowgnt_if bus16 ();
    rr_arb4_lowgnt_if bus4 ();

    rr_arb4_lowgnt #(.MAX_HOLD(16), .CNT_W(8)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    rr_arb4_lowgnt #(.MAX_HOLD(4), .CNT_W(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    always #5 clk = ~clk;

    logic [7:0] st16;
    logic [7:0] st4;
    assign st16 = {bus16.gnt_n, bus16.gnt_idx, bus16.gnt_valid, bus16.timeout};
    assign st4  = {bus4.gnt_n,  bus4.gnt_idx,  bus4.gnt_valid,  bus4.timeout};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] c;
        ref_pick = last;
        // Walk from lowest to highest priority; the last hit wins.
        for (int k = 4; k >= 1; k--) begin
            c = last + 2'(k);
            if (r[c]) ref_pick = c;
        end
    endfunction

    task automatic test_reset;
        bus16.req = 4'b0000;
        bus4.req  = 4'b0000;
        #2;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (st16 !== 8'b1111_11_0_0) begin
            n_fail++;
            $display("FAIL reset16: got %b want %b", st16, 8'b1111_11_0_0);
        end
        n_cmp++;
        if (st4 !== 8'b1111_11_0_0) begin
            n_fail++;
            $display("FAIL reset4: got %b want %b", st4, 8'b1111_11_0_0);
        end
        tick;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        n_cmp++;
        if (st16 !== 8'b1111_11_0_0) begin
            n_fail++;
            $display("FAIL reset16_idle: got %b want %b", st16, 8'b1111_11_0_0);
        end
    endtask

    task automatic test_single;
        bus16.req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            tick;
            n_cmp++;
            if (st16 !== 8'b1110_00_1_0) begin
                n_fail++;
                $display("FAIL single_grant[%0d]: got %b want %b", c, st16, 8'b1110_00_1_0);
            end
        end
        bus16.req = 4'b0000;
        tick;
        n_cmp++;
        if (st16 !== 8'b1111_00_0_0) begin
            n_fail++;
            $display("FAIL single_gap: got %b want %b", st16, 8'b1111_00_0_0);
        end
        tick;
        n_cmp++;
        if (st16 !== 8'b1111_00_0_0) begin
            n_fail++;
            $display("FAIL single_idle: got %b want %b", st16, 8'b1111_00_0_0);
        end
    endtask

    task automatic test_rotate;
        logic [1:0] w;
        logic [7:0] exp;
        bus4.req = 4'b1111;
        tick;
        for (int g = 0; g < 5; g++) begin
            w = 2'(g % 4);
            for (int c = 0; c < 4; c++) begin
                exp = {~(4'b0001 << w), w, 1'b1, 1'b0};
                n_cmp++;
                if (st4 !== exp) begin
                    n_fail++;
                    $display("FAIL rotate_grant[%0d.%0d]: got %b want %b", g, c, st4, exp);
                end
                tick;
            end
            exp = {4'b1111, w, 1'b0, 1'b1};
            n_cmp++;
            if (st4 !== exp) begin
                n_fail++;
                $display("FAIL rotate_gap[%0d]: got %b want %b", g, st4, exp);
            end
            tick;
        end
        n_cmp++;
        if (st4 !== 8'b1101_01_1_0) begin
            n_fail++;
            $display("FAIL rotate_next: got %b want %b", st4, 8'b1101_01_1_0);
        end
        bus4.req = 4'b0000;
        tick;
        n_cmp++;
        if (st4 !== 8'b1111_01_0_0) begin
            n_fail++;
            $display("FAIL rotate_release: got %b want %b", st4, 8'b1111_01_0_0);
        end
        tick;
    endtask

    task automatic test_skip;
        bus16.req = 4'b0010;
        tick;
        n_cmp++;
        if (st16 !== 8'b1101_01_1_0) begin
            n_fail++;
            $display("FAIL skip_grant1: got %b want %b", st16, 8'b1101_01_1_0);
        end
        bus16.req = 4'b1011;
        tick;
        n_cmp++;
        if (st16 !== 8'b1101_01_1_0) begin
            n_fail++;
            $display("FAIL skip_hold1: got %b want %b", st16, 8'b1101_01_1_0);
        end
        bus16.req = 4'b1001;
        tick;
        n_cmp++;
        if (st16 !== 8'b1111_01_0_0) begin
            n_fail++;
            $display("FAIL skip_gap: got %b want %b", st16, 8'b1111_01_0_0);
        end
        tick;
        n_cmp++;
        if (st16 !== 8'b0111_11_1_0) begin
            n_fail++;
            $display("FAIL skip_grant3: got %b want %b", st16, 8'b0111_11_1_0);
        end
        bus16.req = 4'b0000;
        tick;
        n_cmp++;
        if (st16 !== 8'b1111_11_0_0) begin
            n_fail++;
            $display("FAIL skip_release: got %b want %b", st16, 8'b1111_11_0_0);
        end
        tick;
    endtask

    task automatic test_hold_limit;
        bus16.req = 4'b0100;
        tick;
        for (int c = 0; c < 16; c++) begin
            n_cmp++;
            if (st16 !== 8'b1011_10_1_0) begin
                n_fail++;
                $display("FAIL hold_grant[%0d]: got %b want %b", c, st16, 8'b1011_10_1_0);
            end
            tick;
        end
        n_cmp++;
        if (st16 !== 8'b1111_10_0_1) begin
            n_fail++;
            $display("FAIL hold_timeout_gap: got %b want %b", st16, 8'b1111_10_0_1);
        end
        tick;
        n_cmp++;
        if (st16 !== 8'b1011_10_1_0) begin
            n_fail++;
            $display("FAIL hold_regrant: got %b want %b", st16, 8'b1011_10_1_0);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        // dut16 is mid-grant to requester 2 here
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (st16 !== 8'b1111_11_0_0) begin
            n_fail++;
            $display("FAIL midreset_async: got %b want %b", st16, 8'b1111_11_0_0);
        end
        bus16.req = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        n_cmp++;
        if (st16 !== 8'b1110_00_1_0) begin
            n_fail++;
            $display("FAIL midreset_first: got %b want %b", st16, 8'b1110_00_1_0);
        end
        bus16.req = 4'b0000;
        tick;
        tick;
    endtask

    task automatic test_random;
        logic       m_grant = 1'b0;
        logic [1:0] m_idx   = 2'd3;
        int         m_cnt   = 0;
        logic       m_to    = 1'b0;
        logic [3:0] smp;
        logic [7:0] exp;
        logic       prev_valid = 1'b0;
        int         run = 0;
        logic       ok;
        bus4.req = 4'b0000;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if ($urandom_range(0, 3) == 0) bus4.req = 4'($urandom_range(0, 15));
            smp = bus4.req;
            tick;
            // reference model step on the sampled request vector
            if (!m_grant) begin
                m_to = 1'b0;
                if (smp != 4'b0000) begin
                    m_idx   = ref_pick(smp, m_idx);
                    m_grant = 1'b1;
                    m_cnt   = 1;
                end
            end else if (!smp[m_idx]) begin
                m_grant = 1'b0;
                m_to    = 1'b0;
            end else if (m_cnt == 4) begin
                m_grant = 1'b0;
                m_to    = 1'b1;
            end else begin
                m_cnt++;
                m_to = 1'b0;
            end
            exp = m_grant ? {~(4'b0001 << m_idx), m_idx, 1'b1, 1'b0}
                          : {4'b1111, m_idx, 1'b0, m_to};
            n_cmp++;
            if (st4 !== exp) begin
                n_fail++;
                $display("FAIL random_model[%0d]: got %b want %b", cyc, st4, exp);
            end
            // invariants
            ok = (bus4.gnt_n == 4'b1111 && !bus4.gnt_valid) ||
                 (bus4.gnt_valid && bus4.gnt_n == ~(4'b0001 << bus4.gnt_idx));
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("FAIL random_onehot[%0d]: got %b want onehot-low or 1111", cyc, bus4.gnt_n);
            end
            run = bus4.gnt_valid ? run + 1 : 0;
            n_cmp++;
            if (run > 4) begin
                n_fail++;
                $display("FAIL random_holdlen[%0d]: got %0d want <= 4", cyc, run);
            end
            if (bus4.gnt_valid && !prev_valid) begin
                n_cmp++;
                if (smp[bus4.gnt_idx] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random_req_at_arb[%0d]: got req %b idx %0d want req bit high",
                             cyc, smp, bus4.gnt_idx);
                end
            end
            prev_valid = bus4.gnt_valid;
        end
        bus4.req = 4'b0000;
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_rotate;
        test_skip;
        test_hold_limit;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rr_arb4_lowgnt
`default_nettype wire
